// File: rtl/arch_map_table.sv
// Architectural (retirement) register map: commits retire bundles, returns displaced
// pregs to the free list, and publishes the committed map in parallel or as a stream.
module arch_map_table #(
  parameter int PREG_NUMBER    = 64,
  parameter int ARCHREG_NUMBER = 32,
  parameter int RETIRE_WIDTH   = 2,
  parameter int RECOVER_WIDTH  = 4,
  parameter int ZERO_HARDWIRED = 1,
  localparam int PREG_W = $clog2(PREG_NUMBER),
  localparam int AREG_W = $clog2(ARCHREG_NUMBER)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [RETIRE_WIDTH-1:0]            retire_en_i,
  input  logic [RETIRE_WIDTH*AREG_W-1:0]     retire_arch_reg_i,
  input  logic [RETIRE_WIDTH*PREG_W-1:0]     new_tag_i,
  output logic                               retire_ready_o,
  output logic [RETIRE_WIDTH-1:0]            free_valid_o,
  output logic [RETIRE_WIDTH*PREG_W-1:0]     free_tag_o,
  output logic [ARCHREG_NUMBER*PREG_W-1:0]   arch_table_recover_o,
  input  logic                               recover_start_i,
  output logic                               recover_valid_o,
  output logic [AREG_W-1:0]                  recover_idx_o,
  output logic [RECOVER_WIDTH*PREG_W-1:0]    recover_data_o,
  output logic                               recover_done_o
);

  localparam int BEATS = ARCHREG_NUMBER / RECOVER_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [PREG_W-1:0]       map      [ARCHREG_NUMBER];
  logic [PREG_W-1:0]       map_next [ARCHREG_NUMBER];
  logic [AREG_W-1:0]       arch      [RETIRE_WIDTH];
  logic [PREG_W-1:0]       tag       [RETIRE_WIDTH];
  logic [PREG_W-1:0]       displaced [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0] eff;
  logic [RETIRE_WIDTH-1:0] free_valid_p1;
  logic [PREG_W-1:0]       free_tag_p1 [RETIRE_WIDTH];
  logic [AREG_W-1:0]       base;

  assign retire_ready_o = (state == IDLE);

  // Ports resolve oldest to youngest: a later port sees earlier same-bundle writes
  // as the displaced tag, and the youngest write wins the map entry.
  always_comb begin
    eff      = '0;
    map_next = map;
    for (int p = 0; p < RETIRE_WIDTH; p++) begin
      arch[p]      = retire_arch_reg_i[p*AREG_W +: AREG_W];
      tag[p]       = new_tag_i[p*PREG_W +: PREG_W];
      eff[p]       = retire_en_i[p] && retire_ready_o &&
                     !((ZERO_HARDWIRED != 0) && (arch[p] == '0));
      displaced[p] = map[arch[p]];
      for (int q = 0; q < p; q++) begin
        if (eff[q] && (arch[q] == arch[p])) displaced[p] = tag[q];
      end
      if (eff[p]) map_next[arch[p]] = tag[p];
    end
  end

  // Stage p1: committed map and freed-tag pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_valid_p1 <= '0;
      for (int p = 0; p < RETIRE_WIDTH; p++) free_tag_p1[p] <= '0;
      for (int i = 0; i < ARCHREG_NUMBER; i++) map[i] <= PREG_W'(i);
    end else begin
      free_valid_p1 <= eff;
      for (int p = 0; p < RETIRE_WIDTH; p++) free_tag_p1[p] <= eff[p] ? displaced[p] : '0;
      map <= map_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (recover_start_i) state_next = STREAM;
      end
      STREAM: begin
        if (cnt == CNT_W'(BEATS - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    free_valid_o = free_valid_p1;
    free_tag_o   = '0;
    for (int p = 0; p < RETIRE_WIDTH; p++) free_tag_o[p*PREG_W +: PREG_W] = free_tag_p1[p];
    for (int i = 0; i < ARCHREG_NUMBER; i++) arch_table_recover_o[i*PREG_W +: PREG_W] = map[i];
  end

  // Stream outputs come straight from the state, counter and map flops; idle values are 0.
  always_comb begin
    base            = AREG_W'(int'(cnt) * RECOVER_WIDTH);
    recover_valid_o = (state == STREAM);
    recover_done_o  = (state == STREAM) && (cnt == CNT_W'(BEATS - 1));
    recover_idx_o   = '0;
    recover_data_o  = '0;
    if (state == STREAM) begin
      recover_idx_o = base;
      for (int j = 0; j < RECOVER_WIDTH; j++)
        recover_data_o[j*PREG_W +: PREG_W] = map[base + AREG_W'(j)];
    end
  end

endmodule

// File: tb/tb_arch_map_table.sv
// Bench for arch_map_table: table-driven retire vectors with a free-tag scoreboard,
// then serialised-recovery and mid-stream reset sequences.
module tb_arch_map_table;
  localparam int PW = 6;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     retire_en_i;
  logic [2*AW-1:0] retire_arch_reg_i;
  logic [2*PW-1:0] new_tag_i;
  logic           retire_ready_o;
  logic [1:0]     free_valid_o;
  logic [2*PW-1:0] free_tag_o;
  logic [32*PW-1:0] arch_table_recover_o;
  logic           recover_start_i;
  logic           recover_valid_o;
  logic [AW-1:0]  recover_idx_o;
  logic [4*PW-1:0] recover_data_o;
  logic           recover_done_o;

  arch_map_table #(
    .PREG_NUMBER(64), .ARCHREG_NUMBER(32), .RETIRE_WIDTH(2),
    .RECOVER_WIDTH(4), .ZERO_HARDWIRED(1)
  ) dut (
    .clk(clk), .reset(reset),
    .retire_en_i(retire_en_i), .retire_arch_reg_i(retire_arch_reg_i), .new_tag_i(new_tag_i),
    .retire_ready_o(retire_ready_o), .free_valid_o(free_valid_o), .free_tag_o(free_tag_o),
    .arch_table_recover_o(arch_table_recover_o), .recover_start_i(recover_start_i),
    .recover_valid_o(recover_valid_o), .recover_idx_o(recover_idx_o),
    .recover_data_o(recover_data_o), .recover_done_o(recover_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    en;
    logic [AW-1:0] a0, a1;
    logic [PW-1:0] t0, t1;
    logic [1:0]    fv;
    logic [PW-1:0] ft0, ft1;
    logic [AW-1:0] chk_reg;
    logic [PW-1:0] chk_val;
  } vec_t;

  typedef struct packed {
    logic [1:0]    fv;
    logic [PW-1:0] ft0, ft1;
  } free_t;

  typedef struct packed {
    logic [AW-1:0]   idx;
    logic            done;
    logic [4*PW-1:0] data;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  vec_t  vecs [11];
  free_t free_q [$];
  beat_t beat_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] map_at(input int i);
    return arch_table_recover_o[i*PW +: PW];
  endfunction

  function automatic logic [4*PW-1:0] mk(input int e0, input int e1, input int e2, input int e3);
    return {PW'(e3), PW'(e2), PW'(e1), PW'(e0)};
  endfunction

  task automatic drive(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [PW-1:0] t0, input logic [PW-1:0] t1, input logic st);
    retire_en_i       = en;
    retire_arch_reg_i = {a1, a0};
    new_tag_i         = {t1, t0};
    recover_start_i   = st;
  endtask

  task automatic check_identity(input string name);
    int bad = 0;
    for (int i = 0; i < 32; i++) if (map_at(i) !== PW'(i)) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  initial begin
    free_t exp_f;
    beat_t exp_b;
    logic [4*PW-1:0] beat_data [8];
    int cyc;

    //         en     a0     a1     t0     t1     fv     ft0    ft1    chk    val
    vecs[0]  = '{2'b11, 5'd3,  5'd5,  6'd40, 6'd41, 2'b11, 6'd3,  6'd5,  5'd3,  6'd40};
    vecs[1]  = '{2'b11, 5'd7,  5'd7,  6'd50, 6'd51, 2'b11, 6'd7,  6'd50, 5'd7,  6'd51};
    vecs[2]  = '{2'b01, 5'd0,  5'd2,  6'd60, 6'd61, 2'b00, 6'd0,  6'd0,  5'd0,  6'd0};
    vecs[3]  = '{2'b10, 5'd4,  5'd3,  6'd62, 6'd42, 2'b10, 6'd0,  6'd40, 5'd3,  6'd42};
    vecs[4]  = '{2'b11, 5'd0,  5'd3,  6'd63, 6'd44, 2'b10, 6'd0,  6'd42, 5'd3,  6'd44};
    vecs[5]  = '{2'b00, 5'd5,  5'd6,  6'd9,  6'd9,  2'b00, 6'd0,  6'd0,  5'd5,  6'd41};
    vecs[6]  = '{2'b11, 5'd10, 5'd11, 6'd20, 6'd21, 2'b11, 6'd10, 6'd11, 5'd10, 6'd20};
    vecs[7]  = '{2'b11, 5'd5,  5'd7,  6'd22, 6'd23, 2'b11, 6'd41, 6'd51, 5'd7,  6'd23};
    vecs[8]  = '{2'b11, 5'd31, 5'd31, 6'd1,  6'd2,  2'b11, 6'd31, 6'd1,  5'd31, 6'd2};
    vecs[9]  = '{2'b11, 5'd0,  5'd0,  6'd5,  6'd6,  2'b00, 6'd0,  6'd0,  5'd0,  6'd0};
    vecs[10] = '{2'b10, 5'd12, 5'd12, 6'd30, 6'd31, 2'b10, 6'd0,  6'd12, 5'd12, 6'd31};

    reset = 1'b0;
    drive(2'b00, '0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_identity("reset_identity");
    check("reset_free_valid", 64'(free_valid_o), 64'd0);
    check("reset_ready", 64'(retire_ready_o), 64'd1);
    check("reset_rvalid", 64'(recover_valid_o), 64'd0);
    check("reset_done", 64'(recover_done_o), 64'd0);
    check("reset_idx", 64'(recover_idx_o), 64'd0);
    check("reset_data", 64'(recover_data_o), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].en, vecs[i].a0, vecs[i].a1, vecs[i].t0, vecs[i].t1, 1'b0);
      free_q.push_back('{vecs[i].fv, vecs[i].ft0, vecs[i].ft1});
      @(posedge clk); #1;
      drive(2'b00, '0, '0, '0, '0, 1'b0);
      exp_f = free_q.pop_front();
      check($sformatf("vec%0d_free_valid", i), 64'(free_valid_o), 64'(exp_f.fv));
      check($sformatf("vec%0d_free_tag0", i), 64'(free_tag_o[PW-1:0]), 64'(exp_f.ft0));
      check($sformatf("vec%0d_free_tag1", i), 64'(free_tag_o[2*PW-1:PW]), 64'(exp_f.ft1));
      check($sformatf("vec%0d_map", i), 64'(map_at(int'(vecs[i].chk_reg))), 64'(vecs[i].chk_val));
    end
    @(posedge clk); #1;
    check("free_pulse_clears", 64'(free_valid_o), 64'd0);

    // Serialised recovery with a same-cycle retire of r9<-33
    beat_data[0] = mk(0, 1, 2, 44);
    beat_data[1] = mk(4, 22, 6, 23);
    beat_data[2] = mk(8, 33, 20, 21);
    beat_data[3] = mk(31, 13, 14, 15);
    beat_data[4] = mk(16, 17, 18, 19);
    beat_data[5] = mk(20, 21, 22, 23);
    beat_data[6] = mk(24, 25, 26, 27);
    beat_data[7] = mk(28, 29, 30, 2);
    drive(2'b01, 5'd9, 5'd0, 6'd33, 6'd0, 1'b1);
    for (int k = 0; k < 8; k++) beat_q.push_back('{AW'(k*4), (k == 7), beat_data[k]});
    @(posedge clk); #1;
    drive(2'b00, '0, '0, '0, '0, 1'b0);
    cyc = 0;
    while (beat_q.size() > 0 && cyc < 20) begin
      if (recover_valid_o) begin
        exp_b = beat_q.pop_front();
        check($sformatf("beat%0d_idx", exp_b.idx), 64'(recover_idx_o), 64'(exp_b.idx));
        check($sformatf("beat%0d_done", exp_b.idx), 64'(recover_done_o), 64'(exp_b.done));
        check($sformatf("beat%0d_data", exp_b.idx), 64'(recover_data_o), 64'(exp_b.data));
        check($sformatf("beat%0d_ready", exp_b.idx), 64'(retire_ready_o), 64'd0);
        if (exp_b.idx == 5'd12) begin
          drive(2'b01, 5'd2, 5'd0, 6'd55, 6'd0, 1'b1);
        end else if (exp_b.idx == 5'd16) begin
          drive(2'b00, '0, '0, '0, '0, 1'b0);
          check("stream_drop_free", 64'(free_valid_o), 64'd0);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_beats_left", 64'(beat_q.size()), 64'd0);
    check("post_stream_valid", 64'(recover_valid_o), 64'd0);
    check("post_stream_done", 64'(recover_done_o), 64'd0);
    check("post_stream_ready", 64'(retire_ready_o), 64'd1);
    check("post_stream_idx", 64'(recover_idx_o), 64'd0);
    check("post_stream_data", 64'(recover_data_o), 64'd0);
    check("stream_dropped_write", 64'(map_at(2)), 64'd2);
    check("stream_retire_applied", 64'(map_at(9)), 64'd33);

    // Reset in the middle of a second stream
    drive(2'b00, '0, '0, '0, '0, 1'b1);
    @(posedge clk); #1;
    drive(2'b00, '0, '0, '0, '0, 1'b0);
    cyc = 0;
    while (!(recover_valid_o && recover_idx_o == 5'd12) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_beat3", 64'(recover_idx_o), 64'd12);
    reset = 1'b0;
    #1;
    check("midrst_valid", 64'(recover_valid_o), 64'd0);
    check("midrst_done", 64'(recover_done_o), 64'd0);
    check("midrst_ready", 64'(retire_ready_o), 64'd1);
    check("midrst_data", 64'(recover_data_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_identity("midrst_identity");
    check("midrst_ready_after", 64'(retire_ready_o), 64'd1);
    check("midrst_valid_after", 64'(recover_valid_o), 64'd0);
    check("midrst_free_after", 64'(free_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
